// File: rtl/joy_db15_if.sv
// DB15 serial joystick link: host-driven shift clock and load strobe, device-driven data.
interface joy_db15_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick responder: emulates the adapter's PISO shift chain,
// snapshotting both players on load and shifting one bit per host clock rise.
module joy_db15_tx #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] joystick1,
  input  logic [WIDTH-1:0] joystick2,
  joy_db15_if.slave        link,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int N     = 2 * WIDTH;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_s_d;
  logic [N-1:0]           shreg;
  logic [CNT_W-1:0]       cnt;
  logic                   clk_s;
  logic                   load_s;
  logic                   clk_rise;
  logic [N-1:0]           frame;

  // Buttons are active-high at the port but active-low on the wire.
  assign frame    = {~joystick2, ~joystick1};
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign load_s   = load_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_s_d;

  // Synchronizers idle high so releasing reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      load_sync <= '1;
      clk_s_d   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], link.joy_clk};
      load_sync <= {load_sync[SYNC_STAGES-2:0], link.joy_load};
      clk_s_d   <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      shreg         <= '1;
      cnt           <= '0;
      link.joy_data <= 1'b1;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // An asserted load wins over everything, including a same-cycle clock rise.
      if (!load_s) begin
        state         <= ST_LOAD;
        shreg         <= frame;
        cnt           <= '0;
        overrun       <= 1'b0;
        link.joy_data <= frame[0];
        busy          <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            link.joy_data <= 1'b1;
            busy          <= 1'b0;
            if (clk_rise) overrun <= 1'b1;
          end
          ST_LOAD: begin
            state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (clk_rise) begin
              shreg <= {1'b1, shreg[N-1:1]};
              cnt   <= cnt + 1'b1;
              if (cnt == CNT_W'(N - 1)) begin
                state         <= ST_IDLE;
                link.joy_data <= 1'b1;
                busy          <= 1'b0;
                frame_done    <= 1'b1;
              end else begin
                link.joy_data <= shreg[1];
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Device-side responder for the DB15 serial joystick link; it is the other end of the host-side DB15 reader.
- Emulates the adapter's parallel-in/serial-out shift-register chain. It snapshots two players' button states on LOAD and shifts them out on JOY_DATA, one bit per JOY_CLK rising edge.
- Used in loopback/self-test builds and in the joystick-adapter bridge core. It lets the reader be exercised without physical hardware.

Parameters:
- WIDTH, 12, bits per player in the frame (FEDCBAUDLR + 2 system buttons).
- SYNC_STAGES, 2, synchronizer flops on joy_clk and joy_load (min 2).

Ports:
- clk  input  1  system clock, 40-50 MHz, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- joystick1  input  WIDTH  player 1 buttons, active-high, bit0=R, bit1=L, bit2=D, bit3=U, bit4..=buttons.
- joystick2  input  WIDTH  player 2 buttons, same layout.
- joy_clk  input  1  serial shift clock from host, asynchronous to clk.
- joy_load  input  1  parallel load from host, active-low, asynchronous to clk.
- joy_data  output  1  serial data to host, active-low on the wire.
- busy  output  1  high while frame bits remain unshifted.
- frame_done  output  1  one-clk pulse when the last frame bit has been shifted past.
- overrun  output  1  sticky: joy_clk rising edge seen after frame exhausted; cleared by next load.

Behaviour:
Reset (reset_n low, async):
- Shift register all 1s; joy_data=1, busy=0, frame_done=0, overrun=0, bit counter=0.
- Synchronizer flops reset to 1 on both inputs, so no edge is detected on release.

Input handling:
- joy_clk and joy_load each pass through SYNC_STAGES flops: clk_s and load_s.
- A clk rise is detected when clk_s=1 and the previous clk_s=0.

Frame:
- Frame length is 2*WIDTH bits.
- Frame bit k=~joystick1[k] for k<WIDTH, and ~joystick2[k-WIDTH] otherwise.
- Bit 0 is presented first.

States:
- IDLE:
  - joy_data=1, busy=0.
  - load_s=0 -> LOAD.
- LOAD:
  - Every clk while load_s=0: shift register <= frame, counter <= 0, overrun <= 0.
  - This is transparent: the input snapshot tracks the inputs each clk.
  - joy_data=frame bit 0, busy=1.
  - load_s=1 -> SHIFT, holding the last snapshot.
- SHIFT:
  - On each clk rise: shift right, filling from the top with 1, and counter++.
  - joy_data = new bit 0.
  - The shift that takes counter from 2*WIDTH-1 to 2*WIDTH sets joy_data=1, busy=0, pulses frame_done, and goes to IDLE.
- IDLE with a clk rise and no load: overrun <= 1; joy_data stays 1.

Precedence and boundary cases:
- load_s=0 overrides any clk rise in the same clk, in every state.
- load_s going low mid-frame aborts the frame and reloads. No frame_done is produced for the aborted frame.
- Clk rises while load_s=0 are ignored and do not shift.
- Input changes after load_s rises do not affect the frame in flight.

Latency and host timing:
- joy_data changes exactly SYNC_STAGES+1 clk cycles after the joy_clk or joy_load pin edge.
- The host must hold each joy_clk level ≥ SYNC_STAGES+2 clk periods.
- The host samples joy_data before its next rising edge.

Output registering:
- All outputs are registered with no combinational path from inputs.
- frame_done is exactly 1 cycle wide.

Counter width: clog2(2*WIDTH+1).

Test Plan:
1. Reset release, no host activity -> joy_data=1, busy=0, overrun=0 for 100 clks.
2. joystick1=12'h011, joystick2=12'h800; load pulse, then 24 clk rises -> bits sampled before each rise read 0,1,1,1,0,1×7,1×11,0. After the 24th rise: joy_data=1, frame_done single pulse, busy=0.
3. joystick1 changes from 12'h000 to 12'hFFF 5 clks after load release, then shift the frame -> frame reflects 12'h000 (all 1s on wire for P1).
4. Load, 10 clk rises, then load again, then 24 rises -> full correct frame from bit 0, with exactly one frame_done.
5. Complete a frame, then 1 extra clk rise -> overrun=1, joy_data=1. Next load -> overrun=0.
6. joy_load low coincident with joy_clk rise -> no shift; joy_data=frame bit 0. Also assert reset_n low mid-frame -> outputs immediately return to reset values.
